// File: rtl/fp_pkg.sv
// Shared definitions for the floating_integer datapath: converter states,
// exponent bias and packed float width.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int DEF_EXP_W = 4;
    localparam int DEF_MAN_W = 8;
    localparam int FLOAT_W   = 1 + DEF_EXP_W + DEF_MAN_W;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int float_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a left-normalised magnitude down to a MAN_W-bit
// stored mantissa; carry flags a round-up that overflowed the significand.
module fp_round_rne #(
    parameter int INT_W = 8,
    parameter int MAN_W = 8
) (
    input  logic [INT_W-1:0] mag,
    output logic [MAN_W-1:0] man,
    output logic             carry
);

    generate
        if (MAN_W + 1 >= INT_W) begin : g_pad
            localparam int PAD = MAN_W + 1 - INT_W;
            // The significand holds every magnitude bit: drop the hidden bit, zero-fill below.
            assign man   = MAN_W'((MAN_W + 1)'(mag) << PAD);
            assign carry = 1'b0;
        end else begin : g_rnd
            localparam int LOW = INT_W - MAN_W - 1;
            logic [MAN_W:0] top;
            logic           guard;
            logic           sticky;
            logic           inc;

            assign top   = mag[INT_W-1 -: MAN_W+1];
            assign guard = mag[LOW-1];
            if (LOW > 1) begin : g_sticky
                assign sticky = |mag[LOW-2:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end

            assign inc   = guard & (sticky | top[0]);
            assign man   = top[MAN_W-1:0] + MAN_W'(inc);
            // Only an all-ones significand can carry out; the mantissa wraps to zero.
            assign carry = inc & (&top);
        end
    endgenerate

endmodule

// File: rtl/int_to_fp_seq.sv
// Sequential integer-to-float converter: captures one operand per valid/ready
// handshake, normalises one shift per cycle, rounds RNE and saturates to infinity.
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter int INT_W     = 8,
    parameter int EXP_W     = 4,
    parameter int MAN_W     = 8,
    parameter bit TWOS_COMP = 1'b0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [INT_W-1:0]                 i_int,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [float_w(EXP_W, MAN_W)-1:0] o_float,
    output logic                             o_ovf
);

    localparam logic [EXP_W:0]   EXP_INIT = (EXP_W + 1)'(bias(EXP_W) + INT_W - 1);
    localparam logic [EXP_W+1:0] EXP_INF  = (EXP_W + 2)'((1 << EXP_W) - 1);

    state_t                             state, next_state;
    logic                               sign;
    logic [INT_W-1:0]                   mag, mag_in;
    logic [EXP_W:0]                     expo;
    logic                               norm_done;
    logic [MAN_W-1:0]                   man_rnd;
    logic                               carry;
    logic [EXP_W+1:0]                   exp_rnd;
    logic [float_w(EXP_W, MAN_W)-1:0]   float_d;
    logic                               ovf_d;

    generate
        if (TWOS_COMP) begin : g_twos
            assign mag_in = i_int[INT_W-1] ? -i_int : i_int;
        end else begin : g_signmag
            assign mag_in = {1'b0, i_int[INT_W-2:0]};
        end
    endgenerate

    assign norm_done = (mag == '0) || mag[INT_W-1];
    assign o_ready   = (state == IDLE);
    assign o_valid   = (state == DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (i_valid)   next_state = NORM;
            NORM:    if (norm_done) next_state = ROUND;
            ROUND:                  next_state = DONE;
            DONE:    if (i_ready)   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    fp_round_rne #(
        .INT_W(INT_W),
        .MAN_W(MAN_W)
    ) u_round (
        .mag  (mag),
        .man  (man_rnd),
        .carry(carry)
    );

    assign exp_rnd = {1'b0, expo} + (EXP_W + 2)'(carry);

    always_comb begin
        float_d = {sign, exp_rnd[EXP_W-1:0], man_rnd};
        ovf_d   = 1'b0;
        if (mag == '0) begin
            float_d = {sign, {(EXP_W + MAN_W){1'b0}}};
        end else if (exp_rnd >= EXP_INF) begin
            float_d = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d   = 1'b1;
        end
    end

    // NOTE: the datapath is reset too, so a conversion abandoned by reset leaves no stale result on o_float.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sign    <= 1'b0;
            mag     <= '0;
            expo    <= '0;
            o_float <= '0;
            o_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    sign <= i_int[INT_W-1];
                    mag  <= mag_in;
                    expo <= EXP_INIT;
                end
                NORM: if (!norm_done) begin
                    mag  <= mag << 1;
                    expo <= expo - (EXP_W + 1)'(1);
                end
                ROUND: begin
                    o_float <= float_d;
                    o_ovf   <= ovf_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Self-checking bench: four converter configurations checked against an
// arithmetic reference model with directed and random operands.
module tb_int_to_fp_seq;
    import fp_pkg::*;

    localparam int INT_WS [4] = '{8, 8, 12, 8};
    localparam int EXP_WS [4] = '{4, 4, 5, 3};
    localparam int MAN_WS [4] = '{8, 8, 4, 8};
    localparam bit TCS    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vin  [4];
    logic rin  [4];
    logic ordy [4];
    logic ovld [4];
    logic oovf [4];
    logic [7:0]         d0, d1, d3;
    logic [11:0]        d2;
    logic [FLOAT_W-1:0] f0, f1;
    logic [9:0]         f2;
    logic [11:0]        f3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    int_to_fp_seq u_sm (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[0]), .o_ready(ordy[0]), .i_int(d0),
        .o_valid(ovld[0]), .i_ready(rin[0]), .o_float(f0), .o_ovf(oovf[0])
    );

    int_to_fp_seq #(.TWOS_COMP(1'b1)) u_tc (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[1]), .o_ready(ordy[1]), .i_int(d1),
        .o_valid(ovld[1]), .i_ready(rin[1]), .o_float(f1), .o_ovf(oovf[1])
    );

    int_to_fp_seq #(.INT_W(12), .EXP_W(5), .MAN_W(4)) u_rnd (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[2]), .o_ready(ordy[2]), .i_int(d2),
        .o_valid(ovld[2]), .i_ready(rin[2]), .o_float(f2), .o_ovf(oovf[2])
    );

    int_to_fp_seq #(.EXP_W(3)) u_ovf (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[3]), .o_ready(ordy[3]), .i_int(d3),
        .o_valid(ovld[3]), .i_ready(rin[3]), .o_float(f3), .o_ovf(oovf[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fout(input int idx);
        case (idx)
            0:       return 32'(f0);
            1:       return 32'(f1);
            2:       return 32'(f2);
            default: return 32'(f3);
        endcase
    endfunction

    task automatic drive(input int idx, input logic v, input logic [31:0] data);
        vin[idx] = v;
        case (idx)
            0:       d0 = data[7:0];
            1:       d1 = data[7:0];
            2:       d2 = data[11:0];
            default: d3 = data[7:0];
        endcase
    endtask

    // Reference: value -> |value| -> floor(log2) -> RNE by integer remainder.
    task automatic model(input int idx, input logic [31:0] raw,
                         output logic [31:0] ef, output logic eo, output int el);
        int     iw = INT_WS[idx];
        int     ew = EXP_WS[idx];
        int     mw = MAN_WS[idx];
        bit     sgn;
        longint v, mag, q, r, half;
        int     e, expo, shift;
        sgn = raw[iw-1];
        eo  = 1'b0;
        v   = longint'(raw) & ((longint'(1) << iw) - 1);
        if (TCS[idx]) begin
            if (sgn) v = v - (longint'(1) << iw);
            mag = (v < 0) ? -v : v;
        end else begin
            mag = v & ((longint'(1) << (iw - 1)) - 1);
        end
        if (mag == 0) begin
            ef = 32'(sgn) << (ew + mw);
            el = 2;
            return;
        end
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        el   = iw - 1 - e + 2;
        expo = (1 << (ew - 1)) - 1 + e;
        if (e <= mw) begin
            q = mag << (mw - e);
        end else begin
            shift = e - mw;
            q     = mag >> shift;
            r     = mag - (q << shift);
            half  = longint'(1) << (shift - 1);
            if (r > half || (r == half && q[0])) q++;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                expo++;
            end
        end
        if (expo >= (1 << ew) - 1) begin
            ef = (32'(sgn) << (ew + mw)) | (32'((1 << ew) - 1) << mw);
            eo = 1'b1;
        end else begin
            ef = (32'(sgn) << (ew + mw)) | (32'(expo) << mw) | 32'(q - (longint'(1) << mw));
        end
    endtask

    task automatic run(input int idx, input logic [31:0] raw, input logic [31:0] ef,
                       input logic eo, input int el, input int hold);
        int cyc;
        @(negedge clk);
        check($sformatf("ready_idle%0d", idx), 32'(ordy[idx]), 32'd1);
        drive(idx, 1'b1, raw);
        @(posedge clk);
        #1;
        drive(idx, 1'b0, $urandom);
        rin[idx] = 1'($urandom);
        check($sformatf("ready_busy%0d", idx), 32'(ordy[idx]), 32'd0);
        cyc = 0;
        while (!ovld[idx] && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!ovld[idx]) rin[idx] = 1'($urandom);
        end
        check($sformatf("latency%0d_%0h", idx, raw), 32'(cyc), 32'(el));
        check($sformatf("float%0d_%0h", idx, raw), fout(idx), ef);
        check($sformatf("ovf%0d_%0h", idx, raw), 32'(oovf[idx]), 32'(eo));
        if (hold > 0) rin[idx] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            drive(idx, 1'($urandom), $urandom);
            @(posedge clk);
            #1;
            check($sformatf("hold_valid%0d", idx), 32'(ovld[idx]), 32'd1);
            check($sformatf("hold_float%0d", idx), fout(idx), ef);
            check($sformatf("hold_ovf%0d", idx), 32'(oovf[idx]), 32'(eo));
            check($sformatf("hold_ready%0d", idx), 32'(ordy[idx]), 32'd0);
        end
        drive(idx, 1'b0, 32'd0);
        rin[idx] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("released%0d", idx), 32'(ovld[idx]), 32'd0);
        check($sformatf("ready_back%0d", idx), 32'(ordy[idx]), 32'd1);
        rin[idx] = 1'b0;
    endtask

    task automatic run_rand(input int idx, input int n);
        logic [31:0] raw, ef;
        logic        eo;
        int          el;
        for (int k = 0; k < n; k++) begin
            raw = $urandom & ((32'd1 << INT_WS[idx]) - 1);
            model(idx, raw, ef, eo, el);
            run(idx, raw, ef, eo, el, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b0, 32'd0);
            rin[i] = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(ordy[i]), 32'd1);
            check($sformatf("rst_valid%0d", i), 32'(ovld[i]), 32'd0);
            check($sformatf("rst_float%0d", i), fout(i), 32'd0);
            check($sformatf("rst_ovf%0d", i), 32'(oovf[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(0, 32'h00, 32'h0000, 1'b0, 2, 0);
        run(0, 32'h80, 32'h1000, 1'b0, 2, 0);
        run(0, 32'h01, 32'h0700, 1'b0, 9, 0);
        run(0, 32'h81, 32'h1700, 1'b0, 9, 0);
        run(0, 32'h7F, 32'h0DFC, 1'b0, 3, 5);
        run(0, 32'hFF, 32'h1DFC, 1'b0, 3, 0);
        run(1, 32'h80, 32'h1E00, 1'b0, 2, 0);
        run(1, 32'hFF, 32'h1700, 1'b0, 9, 0);
        run(2, 32'd51, 32'h14A,  1'b0, 8, 0);
        run(2, 32'd49, 32'h148,  1'b0, 8, 0);
        run(2, 32'd63, 32'h150,  1'b0, 8, 0);
        run(3, 32'd127, 32'h700, 1'b1, 3, 2);
        run(3, 32'd8,   32'h600, 1'b0, 6, 0);

        for (int i = 0; i < 4; i++) run_rand(i, 25);

        // Reset in the middle of normalising 8'h01, after a nonzero result is held.
        run(0, 32'hFF, 32'h1DFC, 1'b0, 3, 0);
        @(negedge clk);
        drive(0, 1'b1, 32'h01);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h00);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(ovld[0]), 32'd0);
        check("midrst_ready", 32'(ordy[0]), 32'd1);
        check("midrst_float", fout(0), 32'd0);
        check("midrst_ovf", 32'(oovf[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 32'h7F, 32'h0DFC, 1'b0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
